apb_fifo_bridge: RTL and testbench
==================================

# apb_fifo_bridge

Parametrised APB3 slave fronting two internal FIFOs: a TX FIFO filled by APB writes and drained by a valid/ready stream, and an RX FIFO filled by a valid/ready stream and drained by APB reads. It is the successor to the single-FIFO, 8-bit APB bridge, with:
- generic width and depth;
- a register map with status/count readback;
- flush control;
- sticky error flags;
- an interrupt output.

It sits between the APB peripheral bus and a streaming datapath.

## Interface
- DATA_W, 32, APB data width and FIFO entry width (8..32)
- DEPTH, 16, entries per FIFO; power of two, ≥2
- ADDR_W, 5, PADDR width
- PCLK  in  1  clock
- PRESETn  in  1  reset PRESETn, asynchronous, active-low; clock PCLK
- PSEL, PENABLE, PWRITE  in  1  APB3 control
- PADDR  in  ADDR_W  byte address; bits [1:0] ignored
- PWDATA  in  DATA_W  write data
- PRDATA  out  DATA_W  read data, valid in access phase
- PREADY  out  1  always 1 (zero wait states)
- PSLVERR  out  1  error response, valid only when PSEL&PENABLE
- tx_valid  out  1  TX FIFO not empty
- tx_data  out  DATA_W  TX FIFO head
- tx_ready  in  1  sink accepts head
- rx_valid  in  1  source presents rx_data
- rx_data  in  DATA_W  incoming word
- rx_ready  out  1  RX FIFO not full
- irq  out  1  level interrupt

## Operation
- Transfer fires on an access cycle, defined as PSEL&PENABLE; all side effects take place at the PCLK edge closing that cycle.
- Register map (byte offsets):
  - 0x00 TXDATA, W: push. R: returns 0, PSLVERR=1.
  - 0x04 RXDATA, R: PRDATA = RX head, pop. W: PSLVERR=1, no effect.
  - 0x08 STATUS, RO: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [15:8] tx_count, [23:16] rx_count. Counts are zero-extended, width $clog2(DEPTH+1). Write → PSLVERR=1.
  - 0x0C CTRL, RW:
    - [0] tx_flush, [1] rx_flush: write-1 self-clearing, always read 0.
    - [5:2] irq_en.
  - 0x10 IRQ_STAT: [0] tx_empty (level), [1] rx_nonempty (level), [2] tx_ovf (sticky), [3] rx_udf (sticky). Write-1-to-clear applies to bits 2–3 only.
  - Any other offset → PSLVERR=1, PRDATA=0.
- Write to TXDATA while tx_full: no push, PSLVERR=1, tx_ovf set.
- Read of RXDATA while rx_empty: no pop, PRDATA=0, PSLVERR=1, rx_udf set.
- irq = |(IRQ_STAT[3:0] & CTRL[5:2]).
- Stream sides:
  - TX pops on tx_valid&tx_ready.
  - RX pushes on rx_valid&rx_ready.
- Flush: resets the chosen FIFO's pointers and count at the closing edge of the CTRL write. A stream or APB push in that same cycle into the flushed FIFO is dropped. Sticky flags are not cleared by flush.

## Timing
- Reset values:
  - PRDATA=0, PSLVERR=0, PREADY=1
  - tx_valid=0, rx_ready=1, irq=0
  - CTRL=0, sticky flags=0, both FIFOs empty
- PRDATA and PSLVERR are combinational from the current address and FIFO state during the access cycle. FIFOs are first-word-fall-through, so there is no read latency.
- Push → tx_valid high the following cycle. Pop → new head visible the following cycle.
- Full/empty are evaluated on registered state at the start of the cycle:
  - APB write to a full TX in the same cycle as a tx pop is still rejected.
  - RX pop on empty in the same cycle as an rx push is still an underflow.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH; an extra wrap bit distinguishes full from empty.
- Sticky set and W1C clear in the same cycle: set wins.
- Reset mid-transfer: all state returns to reset values immediately (asynchronous assert). Deassertion is synchronised externally.

## Structure
- Package apb_fifo_pkg holds:
  - register offset localparams;
  - STATUS/CTRL/IRQ_STAT bit-position constants;
  - a typedef for the IRQ vector.
- Sub-module sync_fifo #(WIDTH, DEPTH) is instantiated twice (TX, RX). It has:
  - push/pop/flush inputs;
  - head, full, empty and count outputs.
- Top level contains the APB decode, CTRL/IRQ registers and error logic.

## Test plan
- Reset, then write 0x11, 0x22, 0x33 to TXDATA with tx_ready=0: STATUS tx_count=3, tx_valid=1, tx_data=0x11. Raise tx_ready: 0x11, 0x22, 0x33 stream out on consecutive cycles, then tx_empty=1.
- DEPTH=16 writes to TXDATA, then a 17th write of 0xAA: 17th has PSLVERR=1 and IRQ_STAT[2]=1. Popping all 16 yields the original data, without 0xAA. W1C 0x4 clears the bit.
- Drive rx_valid with 0xCAFE0001 to 0xCAFE0010 until rx_ready=0: rx_count=16. Reads of RXDATA return the words in order. A 17th read gives PRDATA=0, PSLVERR=1, IRQ_STAT[3]=1.
- CTRL=0x3C with empty TX: irq=1. Push one word: irq stays high because of rx/ovf enables only if set, otherwise drops. Verify irq=0 after masking with CTRL=0.
- Push 5 TX words, write CTRL=0x1 while tx_ready=1: tx_count=0 next cycle, tx_valid=0, CTRL reads 0.
- Assert PRESETn=0 mid-stream with both FIFOs half full: all outputs return to reset values, counts=0.

Source files
------------

// File: rtl/apb_fifo_pkg.sv
// Shared constants for the APB dual-FIFO bridge.
// Register offsets, register bit positions and the IRQ vector type.
package apb_fifo_pkg;

    localparam logic [7:0] OFF_TXDATA   = 8'h00;
    localparam logic [7:0] OFF_RXDATA   = 8'h04;
    localparam logic [7:0] OFF_STATUS   = 8'h08;
    localparam logic [7:0] OFF_CTRL     = 8'h0C;
    localparam logic [7:0] OFF_IRQ_STAT = 8'h10;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_FULL  = 2;
    localparam int ST_RX_EMPTY = 3;
    localparam int ST_TX_CNT   = 8;
    localparam int ST_RX_CNT   = 16;

    localparam int CTRL_TX_FLUSH = 0;
    localparam int CTRL_RX_FLUSH = 1;
    localparam int CTRL_IRQ_EN   = 2;

    localparam int IRQ_TX_EMPTY    = 0;
    localparam int IRQ_RX_NONEMPTY = 1;
    localparam int IRQ_TX_OVF      = 2;
    localparam int IRQ_RX_UDF      = 3;

    typedef logic [3:0] irq_vec_t;

    function automatic logic [31:0] pack_status(
        input logic       tx_full,
        input logic       tx_empty,
        input logic       rx_full,
        input logic       rx_empty,
        input logic [7:0] tx_cnt,
        input logic [7:0] rx_cnt
    );
        logic [31:0] s;
        s = '0;
        s[ST_TX_FULL]  = tx_full;
        s[ST_TX_EMPTY] = tx_empty;
        s[ST_RX_FULL]  = rx_full;
        s[ST_RX_EMPTY] = rx_empty;
        s[ST_TX_CNT +: 8] = tx_cnt;
        s[ST_RX_CNT +: 8] = rx_cnt;
        return s;
    endfunction

endpackage

// File: rtl/apb_fifo_bridge_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush.
// Pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_o = CW'(wptr_q - rptr_q);
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    // A flush in the same cycle drops any concurrent push or pop.
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/apb_fifo_bridge.sv
// APB3 slave with a TX FIFO fed by writes and an RX FIFO drained by reads.
// Zero wait states; status, flush control, sticky errors and a level irq.
module apb_fifo_bridge
    import apb_fifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 5
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ready,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rx_ready,
    output logic              irq
);

    localparam int CW = $clog2(DEPTH + 1);

    logic              access;
    logic [ADDR_W-1:0] addr;
    logic              sel_tx, sel_rx, sel_st, sel_ctrl, sel_irq;

    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0]     tx_cnt, rx_cnt;
    logic [DATA_W-1:0] rx_head;
    logic [31:0]       status;

    logic              tx_push, rx_pop;
    logic              ctrl_wr, irq_wr;
    logic              ovf_set, udf_set;
    logic              tx_flush, rx_flush;

    logic [3:0]        irq_en_q, irq_en_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    irq_vec_t          irq_stat;
    logic              unused_paddr;

    assign unused_paddr = ^PADDR[1:0];

    assign access   = PSEL & PENABLE;
    assign addr     = {PADDR[ADDR_W-1:2], 2'b00};
    assign sel_tx   = (addr == ADDR_W'(OFF_TXDATA));
    assign sel_rx   = (addr == ADDR_W'(OFF_RXDATA));
    assign sel_st   = (addr == ADDR_W'(OFF_STATUS));
    assign sel_ctrl = (addr == ADDR_W'(OFF_CTRL));
    assign sel_irq  = (addr == ADDR_W'(OFF_IRQ_STAT));

    assign status = pack_status(tx_full, tx_empty, rx_full, rx_empty,
                                8'(tx_cnt), 8'(rx_cnt));

    assign irq_stat[IRQ_TX_EMPTY]    = tx_empty;
    assign irq_stat[IRQ_RX_NONEMPTY] = ~rx_empty;
    assign irq_stat[IRQ_TX_OVF]      = ovf_q;
    assign irq_stat[IRQ_RX_UDF]      = udf_q;

    assign PREADY   = 1'b1;
    assign tx_valid = ~tx_empty;
    assign rx_ready = ~rx_full;
    assign irq      = |(irq_stat & irq_en_q);

    always_comb begin
        PRDATA  = '0;
        PSLVERR = 1'b0;
        tx_push = 1'b0;
        rx_pop  = 1'b0;
        ctrl_wr = 1'b0;
        irq_wr  = 1'b0;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (access) begin
            unique case (1'b1)
                sel_tx: begin
                    if (!PWRITE) begin
                        PSLVERR = 1'b1;
                    end else if (tx_full) begin
                        PSLVERR = 1'b1;
                        ovf_set = 1'b1;
                    end else begin
                        tx_push = 1'b1;
                    end
                end
                sel_rx: begin
                    if (PWRITE) begin
                        PSLVERR = 1'b1;
                    end else if (rx_empty) begin
                        PSLVERR = 1'b1;
                        udf_set = 1'b1;
                    end else begin
                        PRDATA = rx_head;
                        rx_pop = 1'b1;
                    end
                end
                sel_st: begin
                    if (PWRITE) PSLVERR = 1'b1;
                    else        PRDATA  = DATA_W'(status);
                end
                sel_ctrl: begin
                    if (PWRITE) ctrl_wr = 1'b1;
                    else        PRDATA  = DATA_W'({irq_en_q, 2'b00});
                end
                sel_irq: begin
                    if (PWRITE) irq_wr = 1'b1;
                    else        PRDATA = DATA_W'(irq_stat);
                end
                default: PSLVERR = 1'b1;
            endcase
        end
    end

    assign tx_flush = ctrl_wr & PWDATA[CTRL_TX_FLUSH];
    assign rx_flush = ctrl_wr & PWDATA[CTRL_RX_FLUSH];

    // Setting a sticky flag wins over a same-cycle W1C.
    always_comb begin
        irq_en_d = irq_en_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (ctrl_wr) irq_en_d = PWDATA[CTRL_IRQ_EN +: 4];
        if (irq_wr && PWDATA[IRQ_TX_OVF]) ovf_d = 1'b0;
        if (irq_wr && PWDATA[IRQ_RX_UDF]) udf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;
        if (udf_set) udf_d = 1'b1;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            irq_en_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    sync_fifo #(
        .WIDTH(DATA_W),
        .DEPTH(DEPTH)
    ) u_tx_fifo (
        .clk_i   (PCLK),
        .rst_ni  (PRESETn),
        .push_i  (tx_push),
        .pop_i   (tx_ready),
        .flush_i (tx_flush),
        .wdata_i (PWDATA),
        .head_o  (tx_data),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_cnt)
    );

    sync_fifo #(
        .WIDTH(DATA_W),
        .DEPTH(DEPTH)
    ) u_rx_fifo (
        .clk_i   (PCLK),
        .rst_ni  (PRESETn),
        .push_i  (rx_valid),
        .pop_i   (rx_pop),
        .flush_i (rx_flush),
        .wdata_i (rx_data),
        .head_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_cnt)
    );

endmodule

// File: tb/tb_apb_fifo_bridge.sv
// Directed scoreboard bench for apb_fifo_bridge.
// Expected stream words are queued on push and compared on output.
module tb_apb_fifo_bridge;

    localparam int DW = 32;
    localparam int DP = 16;
    localparam int AW = 5;

    logic          PCLK;
    logic          PRESETn;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_ready;
    logic          rx_valid;
    logic [DW-1:0] rx_data;
    logic          rx_ready;
    logic          irq;

    int checks;
    int failures;
    logic [31:0] txq[$];
    logic [31:0] rxq[$];
    logic [31:0] rd;
    logic        err;
    int          k;

    apb_fifo_bridge #(
        .DATA_W(DW),
        .DEPTH (DP),
        .ADDR_W(AW)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .tx_ready(tx_ready),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .rx_ready(rx_ready),
        .irq     (irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apb(input logic wr, input logic [AW-1:0] a,
                       input logic [31:0] wd,
                       output logic [31:0] rdat, output logic e);
        @(negedge PCLK);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = a;
        PWDATA  = wd;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        rdat = PRDATA;
        e    = PSLVERR;
        @(posedge PCLK);
        #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    task automatic tx_push(input logic [31:0] d);
        logic [31:0] r;
        logic        e;
        apb(1'b1, 5'h00, d, r, e);
        txq.push_back(d);
        chk("tx_push_err", 32'(e), 32'd0);
    endtask

    task automatic drain_tx();
        int n;
        n = 0;
        @(negedge PCLK);
        tx_ready = 1'b1;
        while (txq.size() > 0 && n < 100) begin
            #1;
            chk("tx_valid", 32'(tx_valid), 32'd1);
            chk("tx_data", tx_data, txq.pop_front());
            @(negedge PCLK);
            n++;
        end
        #1;
        chk("tx_drain_left", 32'(txq.size()), 32'd0);
        chk("tx_valid_end", 32'(tx_valid), 32'd0);
        tx_ready = 1'b0;
    endtask

    task automatic rx_fill(input int maxn, input logic [31:0] base,
                           output int got);
        got = 0;
        for (int i = 0; i < maxn; i++) begin
            @(negedge PCLK);
            rx_valid = 1'b0;
            #1;
            if (!rx_ready) break;
            rx_data  = base + 32'(got);
            rx_valid = 1'b1;
            rxq.push_back(rx_data);
            got++;
        end
        @(negedge PCLK);
        rx_valid = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        PRESETn  = 1'b0;
        PSEL     = 1'b0;
        PENABLE  = 1'b0;
        PWRITE   = 1'b0;
        PADDR    = '0;
        PWDATA   = '0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;

        repeat (2) @(negedge PCLK);
        #1;
        chk("rst_prdata", PRDATA, 32'd0);
        chk("rst_pslverr", 32'(PSLVERR), 32'd0);
        chk("rst_pready", 32'(PREADY), 32'd1);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_irq", 32'(irq), 32'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;

        tx_push(32'h11);
        tx_push(32'h22);
        tx_push(32'h33);
        apb(1'b0, 5'h08, 32'd0, rd, err);
        chk("status_3", rd, 32'h0000_0308);
        chk("tx_valid_3", 32'(tx_valid), 32'd1);
        chk("tx_head_3", tx_data, 32'h11);
        apb(1'b0, 5'h00, 32'd0, rd, err);
        chk("txdata_rd_err", 32'(err), 32'd1);
        chk("txdata_rd_val", rd, 32'd0);
        drain_tx();
        apb(1'b0, 5'h08, 32'd0, rd, err);
        chk("status_empty", rd, 32'h0000_000A);

        for (int i = 0; i < DP; i++) tx_push(32'h100 + 32'(i * 3));
        apb(1'b1, 5'h00, 32'hAA, rd, err);
        chk("ovf_err", 32'(err), 32'd1);
        apb(1'b0, 5'h10, 32'd0, rd, err);
        chk("irq_stat_ovf", rd, 32'h4);
        apb(1'b0, 5'h08, 32'd0, rd, err);
        chk("status_full", rd, 32'h0000_1009);
        drain_tx();
        apb(1'b1, 5'h10, 32'h4, rd, err);
        apb(1'b0, 5'h10, 32'd0, rd, err);
        chk("irq_stat_w1c", rd, 32'h1);

        rx_fill(40, 32'hCAFE_0001, k);
        chk("rx_accepted", 32'(k), 32'd16);
        chk("rx_ready_full", 32'(rx_ready), 32'd0);
        apb(1'b0, 5'h08, 32'd0, rd, err);
        chk("status_rx_full", rd, 32'h0010_0006);
        apb(1'b1, 5'h04, 32'h5, rd, err);
        chk("rxdata_wr_err", 32'(err), 32'd1);
        while (rxq.size() > 0) begin
            apb(1'b0, 5'h04, 32'd0, rd, err);
            chk("rx_rd_data", rd, rxq.pop_front());
            chk("rx_rd_err", 32'(err), 32'd0);
        end
        apb(1'b0, 5'h04, 32'd0, rd, err);
        chk("udf_data", rd, 32'd0);
        chk("udf_err", 32'(err), 32'd1);
        apb(1'b0, 5'h10, 32'd0, rd, err);
        chk("irq_stat_udf", rd, 32'h9);
        apb(1'b1, 5'h10, 32'h8, rd, err);
        apb(1'b0, 5'h10, 32'd0, rd, err);
        chk("irq_stat_udf_clr", rd, 32'h1);
        apb(1'b1, 5'h14, 32'd0, rd, err);
        chk("bad_off_err", 32'(err), 32'd1);
        apb(1'b1, 5'h08, 32'd0, rd, err);
        chk("status_wr_err", 32'(err), 32'd1);

        apb(1'b1, 5'h0C, 32'h3C, rd, err);
        #1;
        chk("irq_tx_empty", 32'(irq), 32'd1);
        apb(1'b0, 5'h0C, 32'd0, rd, err);
        chk("ctrl_rd", rd, 32'h3C);
        tx_push(32'h77);
        #1;
        chk("irq_after_push", 32'(irq), 32'd0);
        apb(1'b1, 5'h0C, 32'h20, rd, err);
        apb(1'b0, 5'h04, 32'd0, rd, err);
        #1;
        chk("irq_udf", 32'(irq), 32'd1);
        apb(1'b1, 5'h10, 32'h8, rd, err);
        #1;
        chk("irq_udf_clr", 32'(irq), 32'd0);
        apb(1'b1, 5'h0C, 32'h0, rd, err);
        #1;
        chk("irq_masked", 32'(irq), 32'd0);

        for (int i = 0; i < 4; i++) tx_push(32'h200 + 32'(i));
        apb(1'b0, 5'h08, 32'd0, rd, err);
        chk("status_5", rd, 32'h0000_0508);
        tx_ready = 1'b1;
        apb(1'b1, 5'h0C, 32'h1, rd, err);
        tx_ready = 1'b0;
        txq.delete();
        chk("flush_tx_valid", 32'(tx_valid), 32'd0);
        apb(1'b0, 5'h08, 32'd0, rd, err);
        chk("flush_status", rd, 32'h0000_000A);
        apb(1'b0, 5'h0C, 32'd0, rd, err);
        chk("flush_ctrl_rd", rd, 32'd0);

        for (int i = 0; i < 8; i++) tx_push(32'h300 + 32'(i));
        rx_fill(8, 32'h400, k);
        chk("rx_half", 32'(k), 32'd8);
        apb(1'b1, 5'h0C, 32'h3C, rd, err);
        #1;
        chk("irq_pre_rst", 32'(irq), 32'd1);
        @(negedge PCLK);
        tx_ready = 1'b1;
        rx_valid = 1'b1;
        PRESETn  = 1'b0;
        #1;
        chk("mrst_tx_valid", 32'(tx_valid), 32'd0);
        chk("mrst_rx_ready", 32'(rx_ready), 32'd1);
        chk("mrst_irq", 32'(irq), 32'd0);
        chk("mrst_prdata", PRDATA, 32'd0);
        chk("mrst_pslverr", 32'(PSLVERR), 32'd0);
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        txq.delete();
        rxq.delete();
        @(negedge PCLK);
        PRESETn = 1'b1;
        apb(1'b0, 5'h08, 32'd0, rd, err);
        chk("mrst_status", rd, 32'h0000_000A);
        apb(1'b0, 5'h0C, 32'd0, rd, err);
        chk("mrst_ctrl", rd, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
